// File: rtl/sensor_trig_pkg.sv
// Shared types and constants for the sensor trigger scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sensor_trig_pkg;

    // FSM encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // Channel indices into ch_en and the trigger vector
    localparam int CH_RADAR = 0;
    localparam int CH_CAM   = 1;
    localparam int CH_IR    = 2;

    // Reset-time active configuration
    localparam logic [15:0] DEF_PERIOD_100US = 16'd1000;
    localparam logic [15:0] DEF_PULSE_CLK    = 16'd300;

    typedef struct packed {
        logic [15:0] period;
        logic [15:0] cam_delay;
        logic [15:0] ir_delay;
        logic [15:0] pulse_clk;
        logic [2:0]  ch_en;
    } trig_cfg_t;

    // A config is usable when both offsets land inside the frame and the
    // pulse is shorter than one tick, so a channel can never retrigger
    // while its own pulse is still high.
    function automatic logic cfg_valid(input trig_cfg_t c, input logic [15:0] pulse_max);
        return (c.period != 16'd0) && (c.cam_delay < c.period) &&
               (c.ir_delay < c.period) && (c.pulse_clk != 16'd0) &&
               (c.pulse_clk <= pulse_max);
    endfunction

endpackage

// File: rtl/sensor_trig_sched_pulse_gen.sv
// Fixed-width pulse stretcher: one strobe in, a pulse of 'width' cycles out.
// Latency: output rises the cycle after the strobe, stays high width cycles.
// Backpressure: none; a strobe during an active pulse reloads the counter.
module trig_pulse_gen (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        strobe,
    input  logic [15:0] width,
    output logic        pulse
);

    logic [15:0] cnt;

    // Load the width on a strobe, then count down to zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 16'd0;
        end else if (strobe) begin
            cnt <= width;
        end else if (cnt != 16'd0) begin
            cnt <= cnt - 16'd1;
        end
    end

    assign pulse = (cnt != 16'd0);

endmodule

// File: rtl/sensor_trig_sched.sv
// Radar/camera/IR frame-start scheduler on a shared 100 us timebase; optional SENSOR_TRIG_EXT_SYNC_EN adds PPS resync.
// Latency: trigger rises one cycle after its event strobe; config applies next cycle (idle/drain) or at frame boundary (run).
// Backpressure: none; i_cfg_load is a strobe, invalid loads are dropped and flagged on o_cfg_err.
module sensor_trig_sched
    import sensor_trig_pkg::*;
#(
    parameter int CONFIG_CLK = 200,
    parameter int DEF_PERIOD = int'(DEF_PERIOD_100US),
    parameter int DEF_PULSE  = int'(DEF_PULSE_CLK)
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef SENSOR_TRIG_EXT_SYNC_EN
    input  logic        i_ext_sync,
`endif
    input  logic        i_arm,
    input  logic        i_cfg_load,
    input  logic [15:0] i_cfg_period_100us,
    input  logic [15:0] i_cfg_cam_delay_100us,
    input  logic [15:0] i_cfg_ir_delay_100us,
    input  logic [15:0] i_cfg_pulse_clk,
    input  logic [2:0]  i_cfg_ch_en,
    output logic        o_radar_framestart,
    output logic        o_camera_framestart,
    output logic        o_ir_framestart,
    output logic        o_busy,
    output logic [31:0] o_frame_cnt,
    output logic        o_cfg_err
);

    localparam int TICK_DIV = CONFIG_CLK * 100;
    localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [15:0]   PULSE_MAX = 16'(TICK_DIV - 1);
    localparam trig_cfg_t CFG_RESET = '{period: 16'(DEF_PERIOD), cam_delay: 16'd0,
                                        ir_delay: 16'd0, pulse_clk: 16'(DEF_PULSE),
                                        ch_en: 3'b111};

    logic [1:0]    state, state_nxt;
    logic [TW-1:0] tick;
    logic [15:0]   pos;
    trig_cfg_t     cfg_act, cfg_pend, cfg_in;
    logic          pend_vld;
    logic          load_ok, running, slot_start, frame_strobe, boundary, resync;
    logic [2:0]    strobe, pulse;

    assign cfg_in = '{period: i_cfg_period_100us, cam_delay: i_cfg_cam_delay_100us,
                      ir_delay: i_cfg_ir_delay_100us, pulse_clk: i_cfg_pulse_clk,
                      ch_en: i_cfg_ch_en};
    assign load_ok = i_cfg_load && cfg_valid(cfg_in, PULSE_MAX);

    assign running = (state == ST_RUN);

`ifdef SENSOR_TRIG_EXT_SYNC_EN
    logic [2:0] sync_q;

    // Two-flop synchronizer plus one history flop for rising-edge detect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 3'b000;
        end else begin
            sync_q <= {sync_q[1:0], i_ext_sync};
        end
    end

    assign resync = running && sync_q[1] && !sync_q[2];
`else
    assign resync = 1'b0;
`endif

    // Strobes stop the very cycle arm drops, even before DRAIN is entered
    assign slot_start   = running && i_arm && (tick == '0);
    assign frame_strobe = slot_start && (pos == 16'd0);
    assign strobe[CH_RADAR] = frame_strobe && cfg_act.ch_en[CH_RADAR];
    assign strobe[CH_CAM]   = slot_start && (pos == cfg_act.cam_delay) && cfg_act.ch_en[CH_CAM];
    assign strobe[CH_IR]    = slot_start && (pos == cfg_act.ir_delay)  && cfg_act.ch_en[CH_IR];

    // Last cycle of a frame (or external resync): pending config takes over here
    assign boundary = running && (((tick == TICK_LAST) && (pos >= cfg_act.period - 16'd1)) || resync);

    // Next-state decode; DRAIN waits for every trigger to finish its full width
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (i_arm)          state_nxt = ST_RUN;
            ST_RUN:   if (!i_arm)         state_nxt = ST_DRAIN;
            ST_DRAIN: if (pulse == 3'b000) state_nxt = ST_IDLE;
            default:                      state_nxt = ST_IDLE;
        endcase
    end

    // State, busy flag and frame counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            o_busy      <= 1'b0;
            o_frame_cnt <= 32'd0;
        end else begin
            state  <= state_nxt;
            o_busy <= (state_nxt != ST_IDLE);
            if ((state == ST_IDLE) && i_arm) begin
                o_frame_cnt <= 32'd0;
            end else if (frame_strobe) begin
                o_frame_cnt <= o_frame_cnt + 32'd1;
            end
        end
    end

    // Timebase: tick counter inside a 100 us slot, slot position inside the frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick <= '0;
            pos  <= 16'd0;
        end else if (!running || resync) begin
            tick <= '0;
            pos  <= 16'd0;
        end else if (tick == TICK_LAST) begin
            tick <= '0;
            pos  <= boundary ? 16'd0 : pos + 16'd1;
        end else begin
            tick <= tick + 1'b1;
        end
    end

    // Double-buffered config: immediate when stopped, deferred to the boundary when running
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_act   <= CFG_RESET;
            cfg_pend  <= CFG_RESET;
            pend_vld  <= 1'b0;
            o_cfg_err <= 1'b0;
        end else begin
            if (i_cfg_load) begin
                o_cfg_err <= !load_ok;
            end
            if (load_ok && !running) begin
                cfg_act  <= cfg_in;
                pend_vld <= 1'b0;
            end else begin
                if (boundary && pend_vld) begin
                    cfg_act  <= cfg_pend;
                    pend_vld <= 1'b0;
                end
                if (load_ok) begin
                    cfg_pend <= cfg_in;
                    pend_vld <= 1'b1;
                end
            end
        end
    end

    trig_pulse_gen u_radar (.clk(clk), .rst_n(rst_n), .strobe(strobe[CH_RADAR]),
                            .width(cfg_act.pulse_clk), .pulse(pulse[CH_RADAR]));
    trig_pulse_gen u_cam   (.clk(clk), .rst_n(rst_n), .strobe(strobe[CH_CAM]),
                            .width(cfg_act.pulse_clk), .pulse(pulse[CH_CAM]));
    trig_pulse_gen u_ir    (.clk(clk), .rst_n(rst_n), .strobe(strobe[CH_IR]),
                            .width(cfg_act.pulse_clk), .pulse(pulse[CH_IR]));

    assign o_radar_framestart  = pulse[CH_RADAR];
    assign o_camera_framestart = pulse[CH_CAM];
    assign o_ir_framestart     = pulse[CH_IR];

endmodule

// File: tb/tb_sensor_trig_sched.sv
// Bench for sensor_trig_sched with a 100-cycle tick: directed scenarios plus random traffic.
// Reference model tracks time-in-frame as one cycle count and each trigger as remaining high cycles.
// Sampling is 1 time unit after each rising edge.
module tb_sensor_trig_sched;

    localparam int TICK = 100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_arm = 1'b0;
    logic        i_cfg_load = 1'b0;
    logic [15:0] i_cfg_period_100us = 16'd0;
    logic [15:0] i_cfg_cam_delay_100us = 16'd0;
    logic [15:0] i_cfg_ir_delay_100us = 16'd0;
    logic [15:0] i_cfg_pulse_clk = 16'd0;
    logic [2:0]  i_cfg_ch_en = 3'b000;
    logic        o_radar_framestart, o_camera_framestart, o_ir_framestart;
    logic        o_busy, o_cfg_err;
    logic [31:0] o_frame_cnt;

    sensor_trig_sched #(.CONFIG_CLK(1), .DEF_PERIOD(1000), .DEF_PULSE(300)) dut (
        .clk(clk), .rst_n(rst_n), .i_arm(i_arm), .i_cfg_load(i_cfg_load),
        .i_cfg_period_100us(i_cfg_period_100us), .i_cfg_cam_delay_100us(i_cfg_cam_delay_100us),
        .i_cfg_ir_delay_100us(i_cfg_ir_delay_100us), .i_cfg_pulse_clk(i_cfg_pulse_clk),
        .i_cfg_ch_en(i_cfg_ch_en), .o_radar_framestart(o_radar_framestart),
        .o_camera_framestart(o_camera_framestart), .o_ir_framestart(o_ir_framestart),
        .o_busy(o_busy), .o_frame_cnt(o_frame_cnt), .o_cfg_err(o_cfg_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    int          m_mode;          // 0 stopped, 1 running, 2 draining
    int          m_t;             // cycles since the current frame started
    int          a_per, a_cam, a_ir, a_pw;
    logic [2:0]  a_en;
    int          p_per, p_cam, p_ir, p_pw;
    logic [2:0]  p_en;
    bit          p_vld;
    logic        m_err;
    logic [31:0] m_cnt;
    int          m_rem [3];       // remaining high cycles per trigger

    task automatic model_reset();
        m_mode = 0; m_t = 0;
        a_per = 1000; a_cam = 0; a_ir = 0; a_pw = 300; a_en = 3'b111;
        p_per = 0; p_cam = 0; p_ir = 0; p_pw = 0; p_en = 3'b000; p_vld = 0;
        m_err = 1'b0; m_cnt = 32'd0;
        for (int c = 0; c < 3; c++) m_rem[c] = 0;
    endtask

    // Advance the model across one rising edge using the inputs now applied
    task automatic model_step();
        int  off [3];
        bit  run, fire, bnd, ok, quiet;
        int  nmode;
        int  per, cam, ir, pw;
        run   = (m_mode == 1);
        fire  = run && i_arm && (m_t % TICK == 0);
        quiet = (m_rem[0] == 0) && (m_rem[1] == 0) && (m_rem[2] == 0);
        off[0] = 0; off[1] = a_cam; off[2] = a_ir;
        for (int c = 0; c < 3; c++) begin
            if (fire && (m_t / TICK == off[c]) && a_en[c]) m_rem[c] = a_pw;
            else if (m_rem[c] > 0) m_rem[c] = m_rem[c] - 1;
        end
        if (m_mode == 0 && i_arm) m_cnt = 32'd0;
        else if (fire && m_t == 0) m_cnt = m_cnt + 32'd1;
        bnd = run && (m_t == a_per * TICK - 1);
        nmode = m_mode;
        if (m_mode == 0 && i_arm) nmode = 1;
        else if (m_mode == 1 && !i_arm) nmode = 2;
        else if (m_mode == 2 && quiet) nmode = 0;
        m_t = (run && !bnd) ? m_t + 1 : 0;
        per = int'(i_cfg_period_100us); cam = int'(i_cfg_cam_delay_100us);
        ir = int'(i_cfg_ir_delay_100us); pw = int'(i_cfg_pulse_clk);
        ok = 0;
        if (i_cfg_load) begin
            ok = (per >= 1) && (cam < per) && (ir < per) && (pw >= 1) && (pw <= TICK - 1);
            m_err = !ok;
        end
        if (ok && !run) begin
            a_per = per; a_cam = cam; a_ir = ir; a_pw = pw; a_en = i_cfg_ch_en; p_vld = 0;
        end else begin
            if (bnd && p_vld) begin
                a_per = p_per; a_cam = p_cam; a_ir = p_ir; a_pw = p_pw; a_en = p_en; p_vld = 0;
            end
            if (ok) begin
                p_per = per; p_cam = cam; p_ir = ir; p_pw = pw; p_en = i_cfg_ch_en; p_vld = 1;
            end
        end
        m_mode = nmode;
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        i_cfg_load = 1'b0;
        chk("outs{radar,cam,ir,busy,err}",
            {o_radar_framestart, o_camera_framestart, o_ir_framestart, o_busy, o_cfg_err},
            {m_rem[0] > 0, m_rem[1] > 0, m_rem[2] > 0, m_mode != 0, m_err});
        chk("frame_cnt", o_frame_cnt, m_cnt);
    endtask

    task automatic run_cycles(input int n);
        repeat (n) cycle();
    endtask

    task automatic load(input int per, input int cam, input int ir, input int pw, input logic [2:0] en);
        i_cfg_period_100us = 16'(per);
        i_cfg_cam_delay_100us = 16'(cam);
        i_cfg_ir_delay_100us = 16'(ir);
        i_cfg_pulse_clk = 16'(pw);
        i_cfg_ch_en = en;
        i_cfg_load = 1'b1;
        cycle();
    endtask

    task automatic stop_and_drain();
        int guard;
        i_arm = 1'b0;
        guard = 0;
        while (m_mode != 0 && guard < 500) begin
            cycle();
            guard++;
        end
        if (m_mode != 0) chk("drain_timeout", 1, 0);
        cycle();
    endtask

    initial begin
        int guard;
        model_reset();
        #1;
        chk("reset_outs", {o_radar_framestart, o_camera_framestart, o_ir_framestart, o_busy, o_cfg_err}, 0);
        chk("reset_cnt", o_frame_cnt, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_cycles(3);

        // Default config: all three coincident, 300 cycles wide
        i_arm = 1'b1;
        run_cycles(400);
        stop_and_drain();

        // Base config: radar at 0, camera +300, IR +500, 1000-cycle frames
        load(10, 3, 5, 20, 3'b111);
        i_arm = 1'b1;
        run_cycles(3500);

        // Mid-frame shrink to 4-slot frames, applied at the next boundary
        load(4, 3, 1, 20, 3'b111);
        run_cycles(2000);

        // Rejected load keeps timing, next valid load clears the flag
        load(4, 12, 1, 20, 3'b111);
        run_cycles(300);
        load(10, 3, 5, 20, 3'b111);
        run_cycles(1500);

        // Camera disabled
        load(10, 3, 5, 20, 3'b101);
        run_cycles(2500);
        load(10, 3, 5, 20, 3'b111);
        run_cycles(1200);

        // Drop arm on the fifth high cycle of a radar pulse
        guard = 0;
        while (!(m_mode == 1 && m_rem[0] == 16) && guard < 3000) begin
            cycle();
            guard++;
        end
        if (guard >= 3000) chk("align_radar", 0, 1);
        chk("radar_mid_pulse", o_radar_framestart, 1);
        stop_and_drain();
        chk("idle_after_drain", o_busy, 0);

        // Random configuration, load and arm traffic
        for (int k = 0; k < 20000; k++) begin
            if ($urandom_range(0, 399) == 0) i_arm = ~i_arm;
            if ($urandom_range(0, 299) == 0) begin
                int per;
                per = int'($urandom_range(1, 12));
                load(per, int'($urandom_range(0, per + 1)), int'($urandom_range(0, per + 1)),
                     int'($urandom_range(0, 105)), 3'($urandom_range(0, 7)));
            end else begin
                cycle();
            end
        end
        stop_and_drain();

        // Async reset in the middle of a pulse, with the error flag set
        load(10, 3, 5, 20, 3'b111);
        load(0, 0, 0, 20, 3'b111);
        i_arm = 1'b1;
        guard = 0;
        while (!(m_mode == 1 && m_rem[0] == 10) && guard < 3000) begin
            cycle();
            guard++;
        end
        if (guard >= 3000) chk("align_reset", 0, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outs", {o_radar_framestart, o_camera_framestart, o_ir_framestart, o_busy, o_cfg_err}, 0);
        chk("async_reset_cnt", o_frame_cnt, 0);
        model_reset();
        i_arm = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_cycles(5);
        // Back in IDLE with the default config
        i_arm = 1'b1;
        run_cycles(350);
        stop_and_drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
